// File: rtl/pa_partition_mean.sv
// Partitions a source RAM region around a pivot into a destination RAM.
// Words below the pivot fill upward from si; all other words fill downward from ei.
module pa_partition_mean #(
  parameter int SIZE_ADDR = 32,
  parameter int SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_addr_si,
  input  logic [SIZE_ADDR-1:0] i_addr_ei,
  input  logic [SIZE_DATA-1:0] i_mean_value,
  output logic                 o_en_ram,
  output logic [SIZE_ADDR-1:0] o_addr_ram,
  input  logic [SIZE_DATA-1:0] i_data_ram,
  input  logic                 i_valid_ram,
  output logic                 o_wr_en,
  output logic [SIZE_ADDR-1:0] o_wr_addr,
  output logic [SIZE_DATA-1:0] o_wr_data,
  output logic                 o_busy,
  output logic [SIZE_ADDR-1:0] o_addr_split,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [SIZE_ADDR-1:0] ADDR_ONE = SIZE_ADDR'(1);

  state_t               state_q;
  logic [SIZE_ADDR-1:0] rd_ptr_q;
  logic [SIZE_ADDR-1:0] lo_ptr_q;
  logic [SIZE_ADDR-1:0] hi_ptr_q;
  logic [SIZE_ADDR-1:0] ei_q;
  logic [SIZE_DATA-1:0] mean_q;
  logic [SIZE_DATA-1:0] data_q;

  logic                 en_ram_q;
  logic [SIZE_ADDR-1:0] addr_ram_q;
  logic                 wr_en_q;
  logic [SIZE_ADDR-1:0] wr_addr_q;
  logic [SIZE_DATA-1:0] wr_data_q;
  logic                 busy_q;
  logic [SIZE_ADDR-1:0] split_q;
  logic                 done_q;

  logic incoming_low;
  logic held_low;

  assign incoming_low = (i_data_ram < mean_q);
  assign held_low     = (data_q < mean_q);

  // Strobes are set on entry to READ/WRITE/DONE so they are high exactly during that state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      lo_ptr_q   <= '0;
      hi_ptr_q   <= '0;
      ei_q       <= '0;
      mean_q     <= '0;
      data_q     <= '0;
      en_ram_q   <= 1'b0;
      addr_ram_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      split_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            rd_ptr_q <= i_addr_si;
            lo_ptr_q <= i_addr_si;
            hi_ptr_q <= i_addr_ei;
            ei_q     <= i_addr_ei;
            mean_q   <= i_mean_value;
            busy_q   <= 1'b1;
            if (i_addr_si <= i_addr_ei) begin
              state_q    <= S_READ;
              en_ram_q   <= 1'b1;
              addr_ram_q <= i_addr_si;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              split_q <= i_addr_si;
            end
          end
        end
        S_READ: begin
          en_ram_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (i_valid_ram) begin
            data_q    <= i_data_ram;
            wr_en_q   <= 1'b1;
            wr_data_q <= i_data_ram;
            wr_addr_q <= incoming_low ? lo_ptr_q : hi_ptr_q;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          if (held_low) lo_ptr_q <= lo_ptr_q + ADDR_ONE;
          else          hi_ptr_q <= hi_ptr_q - ADDR_ONE;
          if (rd_ptr_q == ei_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            split_q <= held_low ? (lo_ptr_q + ADDR_ONE) : lo_ptr_q;
          end else begin
            rd_ptr_q   <= rd_ptr_q + ADDR_ONE;
            en_ram_q   <= 1'b1;
            addr_ram_q <= rd_ptr_q + ADDR_ONE;
            state_q    <= S_READ;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_en_ram     = en_ram_q;
  assign o_addr_ram   = addr_ram_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = busy_q;
  assign o_addr_split = split_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_pa_partition_mean.sv
// Bench for pa_partition_mean: a source RAM responder with random latency, a write
// logger, and a reference partition model computed per run.
module tb_pa_partition_mean;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [AW-1:0] i_addr_si;
  logic [AW-1:0] i_addr_ei;
  logic [DW-1:0] i_mean_value;
  logic          o_en_ram;
  logic [AW-1:0] o_addr_ram;
  logic [DW-1:0] i_data_ram;
  logic          i_valid_ram;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_busy;
  logic [AW-1:0] o_addr_split;
  logic          o_done;

  always #5 i_clk = ~i_clk;

  pa_partition_mean #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_addr_si(i_addr_si), .i_addr_ei(i_addr_ei), .i_mean_value(i_mean_value),
    .o_en_ram(o_en_ram), .o_addr_ram(o_addr_ram),
    .i_data_ram(i_data_ram), .i_valid_ram(i_valid_ram),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_addr_split(o_addr_split), .o_done(o_done)
  );

  logic [DW-1:0] src [0:63];
  logic          resp_valid, spur_valid;
  logic [DW-1:0] resp_data, spur_data;
  assign i_valid_ram = resp_valid | spur_valid;
  assign i_data_ram  = spur_valid ? spur_data : resp_data;

  int tests_run, tests_failed;
  int rd_cnt, resp_cnt, overlap_err, done_cnt;
  int lat_max, rst_gen;
  logic [AW-1:0] split_seen;
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];

  int            resp_lat, resp_gen;
  logic [AW-1:0] resp_a;

  // Source RAM: answers each read after 1..lat_max cycles; a reset cancels the pending answer.
  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_en_ram) begin
        resp_a   = o_addr_ram;
        resp_gen = rst_gen;
        resp_lat = int'($urandom_range(lat_max, 1));
        repeat (resp_lat) @(negedge i_clk);
        if (resp_gen == rst_gen) begin
          resp_data  = src[resp_a[5:0]];
          resp_valid = 1'b1;
          resp_cnt++;
          @(negedge i_clk);
          resp_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_en_ram) begin
        if (rd_cnt != resp_cnt) overlap_err++;
        rd_cnt++;
      end
      if (o_wr_en) begin
        wr_addr_log.push_back(o_wr_addr);
        wr_data_log.push_back(o_wr_data);
      end
      if (o_done) begin
        done_cnt++;
        split_seen = o_addr_split;
      end
    end
  end

  task automatic run_region(input logic [AW-1:0] si, input logic [AW-1:0] ei,
                            input logic [DW-1:0] mean, input int lmax,
                            input bit disturb, input string name);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    logic [AW-1:0] lo, hi, a;
    logic [DW-1:0] w;
    int n, bad;
    bit timed_out;
    // Reference: scan the region in order, lows packed from the bottom, the rest from the top.
    lo = si; hi = ei;
    n = (si <= ei) ? int'(ei - si) + 1 : 0;
    for (int k = 0; k < n; k++) begin
      a = si + AW'(k);
      w = src[a[5:0]];
      if (w < mean) begin ea.push_back(lo); ed.push_back(w); lo = lo + 1; end
      else          begin ea.push_back(hi); ed.push_back(w); hi = hi - 1; end
    end
    wr_addr_log.delete(); wr_data_log.delete();
    rd_cnt = 0; resp_cnt = 0; overlap_err = 0; done_cnt = 0; lat_max = lmax;
    @(negedge i_clk);
    i_addr_si = si; i_addr_ei = ei; i_mean_value = mean; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    tests_run++;
    if (n == 0) begin
      if (o_done !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s done_latency: o_done=%b expected 1", name, o_done);
      end
    end else if (o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy_after_start: o_busy=%b expected 1", name, o_busy);
    end
    if (disturb) begin
      @(negedge i_clk);
      i_addr_si = ~si; i_addr_ei = ei + 5; i_mean_value = $urandom; i_start = 1'b1;
      repeat (2) @(negedge i_clk);
      i_start = 1'b0;
    end
    timed_out = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      if (done_cnt != 0) begin timed_out = 1'b0; break; end
    end
    repeat (3) @(negedge i_clk);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("FAIL %s timeout: no o_done within 4000 cycles", name);
    end
    tests_run++;
    if (wr_addr_log.size() != n) begin
      tests_failed++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_log.size(), n);
    end
    bad = -1;
    for (int k = 0; k < n && k < wr_addr_log.size(); k++)
      if (bad < 0 && (wr_addr_log[k] !== ea[k] || wr_data_log[k] !== ed[k])) bad = k;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL %s write[%0d]: got %0d:%h expected %0d:%h", name, bad,
               wr_addr_log[bad], wr_data_log[bad], ea[bad], ed[bad]);
    end
    tests_run++;
    if (split_seen !== lo) begin
      tests_failed++;
      $display("FAIL %s split: got %0d expected %0d", name, split_seen, lo);
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    tests_run++;
    if (rd_cnt != n) begin
      tests_failed++;
      $display("FAIL %s read_count: got %0d expected %0d", name, rd_cnt, n);
    end
    tests_run++;
    if (overlap_err != 0) begin
      tests_failed++;
      $display("FAIL %s outstanding: %0d reads issued with one pending, expected 0", name, overlap_err);
    end
    tests_run++;
    if (o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_after_done: o_busy=%b expected 0", name, o_busy);
    end
    $display("[TB] %s si=%0d ei=%0d mean=%h writes=%0d split=%0d", name, si, ei, mean,
             wr_addr_log.size(), split_seen);
  endtask

  task automatic check_outputs_zero(input string name);
    tests_run++;
    if ({o_en_ram, o_addr_ram, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_addr_split, o_done} !== '0) begin
      tests_failed++;
      $display("FAIL %s outputs: en=%b addr=%h wr=%b waddr=%h wdata=%h busy=%b split=%h done=%b expected all 0",
               name, o_en_ram, o_addr_ram, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_addr_split, o_done);
    end
  endtask

  task automatic test_reset;
    #1;
    check_outputs_zero("reset_asserted");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_basic;
    logic [AW-1:0] xa [0:3];
    logic [DW-1:0] xd [0:3];
    xa = '{0, 3, 2, 1};
    xd = '{2, 9, 5, 1};
    src[0] = 2; src[1] = 9; src[2] = 5; src[3] = 1;
    run_region(0, 3, 5, 1, 1'b0, "basic");
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= wr_addr_log.size() || wr_addr_log[k] !== xa[k] || wr_data_log[k] !== xd[k]) begin
        tests_failed++;
        $display("FAIL basic_fixed write[%0d]: log size %0d, expected %0d:%0d", k, wr_addr_log.size(), xa[k], xd[k]);
      end
    end
    tests_run++;
    if (split_seen !== 32'd2) begin
      tests_failed++;
      $display("FAIL basic_fixed split: got %0d expected 2", split_seen);
    end
  endtask

  task automatic test_single;
    src[4] = 7;
    run_region(4, 4, 8, 2, 1'b0, "single");
  endtask

  task automatic test_empty;
    run_region(6, 2, 0, 1, 1'b0, "empty");
  endtask

  task automatic test_all_high;
    for (int k = 10; k <= 17; k++) src[k] = 32'hFFFF_FFFF;
    run_region(10, 17, 32'h10, 8, 1'b0, "all_high");
  endtask

  task automatic test_random;
    logic [AW-1:0] si, len;
    for (int t = 0; t < 8; t++) begin
      si  = AW'($urandom_range(40, 0));
      len = AW'($urandom_range(20, 1));
      for (int k = 0; k < 64; k++) src[k] = (t % 2 == 0) ? DW'($urandom_range(15, 0)) : $urandom;
      run_region(si, si + len - 1, (t % 2 == 0) ? DW'($urandom_range(16, 0)) : $urandom,
                 int'($urandom_range(6, 1)), 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    for (int k = 0; k < 8; k++) src[k] = $urandom;
    wr_addr_log.delete(); wr_data_log.delete();
    rd_cnt = 0; resp_cnt = 0; overlap_err = 0; done_cnt = 0; lat_max = 3;
    @(negedge i_clk);
    i_addr_si = 0; i_addr_ei = 7; i_mean_value = 32'h8000_0000; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 500 && seen < 4; c++) begin
      if (o_en_ram) seen++;
      if (seen < 4) @(negedge i_clk);
    end
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    rst_gen++;
    #1;
    check_outputs_zero("reset_mid_run");
    tests_run++;
    if (wr_addr_log.size() != 3) begin
      tests_failed++;
      $display("FAIL reset_mid writes_before_reset: got %0d expected 3", wr_addr_log.size());
    end
    repeat (4) @(negedge i_clk);
    tests_run++;
    if (wr_addr_log.size() != 3 || o_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid writes_during_reset: got %0d writes wr_en=%b expected 3 and 0",
               wr_addr_log.size(), o_wr_en);
    end
    i_rst_n = 1'b1;
    $display("[TB] reset_mid reset applied in WAIT of element 3");
    run_region(0, 1, 32'h8000_0000, 3, 1'b0, "restart");
  endtask

  task automatic test_disturb;
    wr_addr_log.delete(); wr_data_log.delete();
    @(negedge i_clk);
    spur_data = $urandom; spur_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    spur_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    tests_run++;
    if (wr_addr_log.size() != 0 || o_busy !== 1'b0 || o_en_ram !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_valid: writes=%0d busy=%b en=%b expected 0 0 0",
               wr_addr_log.size(), o_busy, o_en_ram);
    end
    for (int k = 0; k < 6; k++) src[k] = DW'($urandom_range(9, 0));
    run_region(0, 5, 5, 4, 1'b1, "disturb");
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rd_cnt = 0; resp_cnt = 0; overlap_err = 0; done_cnt = 0;
    lat_max = 1; rst_gen = 0; split_seen = '0;
    spur_valid = 1'b0; spur_data = '0;
    i_rst_n = 1'b0; i_start = 1'b0;
    i_addr_si = '0; i_addr_ei = '0; i_mean_value = '0;
    for (int k = 0; k < 64; k++) src[k] = '0;
    test_reset();
    test_basic();
    test_single();
    test_empty();
    test_all_high();
    test_random();
    test_reset_mid();
    test_disturb();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
